// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding feeding the ALU.
// Stall holds the stage (refreshing captured rs data from MEM/WB); flush and reset load a bubble.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [3:0]        in_alu_control,
  input  logic              in_src_a_pc,
  input  logic              in_src_b_imm,
  input  logic              in_reg_write,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_control,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1_addr;
  logic [REG_AW-1:0] r_rs2_addr;
  logic [REG_AW-1:0] r_rd_addr;
  logic [3:0]        r_alu_control;
  logic              r_src_a_pc;
  logic              r_src_b_imm;
  logic              r_reg_write;

  logic              w_memwb_active;
  logic              w_exmem_active;
  logic              w_rs1_refresh;
  logic              w_rs2_refresh;
  logic [XLEN-1:0]   w_fwd_rs1;
  logic [XLEN-1:0]   w_fwd_rs2;

  assign w_exmem_active = exmem_reg_write && (exmem_rd != '0);
  assign w_memwb_active = memwb_reg_write && (memwb_rd != '0);
  assign w_rs1_refresh  = w_memwb_active && (memwb_rd == r_rs1_addr);
  assign w_rs2_refresh  = w_memwb_active && (memwb_rd == r_rs2_addr);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
      r_rs1_addr    <= '0;
      r_rs2_addr    <= '0;
      r_rd_addr     <= '0;
      r_alu_control <= 4'b0000;
      r_src_a_pc    <= 1'b0;
      r_src_b_imm   <= 1'b0;
      r_reg_write   <= 1'b0;
    end else if (stall) begin
      // A producer retiring from MEM/WB during the stall would otherwise be lost.
      if (w_rs1_refresh) r_rs1_data <= memwb_result;
      if (w_rs2_refresh) r_rs2_data <= memwb_result;
    end else begin
      r_valid       <= in_valid;
      r_pc          <= in_pc;
      r_rs1_data    <= in_rs1_data;
      r_rs2_data    <= in_rs2_data;
      r_imm         <= in_imm;
      r_rs1_addr    <= in_rs1_addr;
      r_rs2_addr    <= in_rs2_addr;
      r_rd_addr     <= in_rd_addr;
      r_alu_control <= in_alu_control;
      r_src_a_pc    <= in_src_a_pc;
      r_src_b_imm   <= in_src_b_imm;
      r_reg_write   <= in_reg_write && in_valid;
    end
  end

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (w_exmem_active && (exmem_rd == r_rs1_addr))
      w_fwd_rs1 = exmem_result;
    else if (w_rs1_refresh)
      w_fwd_rs1 = memwb_result;
  end

  always_comb begin
    w_fwd_rs2 = r_rs2_data;
    if (w_exmem_active && (exmem_rd == r_rs2_addr))
      w_fwd_rs2 = exmem_result;
    else if (w_rs2_refresh)
      w_fwd_rs2 = memwb_result;
  end

  assign ex_valid      = r_valid;
  assign alu_a         = r_src_a_pc  ? r_pc  : w_fwd_rs1;
  assign alu_b         = r_src_b_imm ? r_imm : w_fwd_rs2;
  assign alu_control   = r_alu_control;
  assign ex_store_data = w_fwd_rs2;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_reg_write  = r_reg_write && r_valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus a randomized run
// checked against a behavioural model of the stage.
module tb_id_ex_operand_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst, stall, flush, in_valid;
  logic [XLEN-1:0]   in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [REG_AW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [3:0]        in_alu_control;
  logic              in_src_a_pc, in_src_b_imm, in_reg_write;
  logic              exmem_reg_write, memwb_reg_write;
  logic [REG_AW-1:0] exmem_rd, memwb_rd;
  logic [XLEN-1:0]   exmem_result, memwb_result;
  logic              ex_valid, ex_reg_write;
  logic [XLEN-1:0]   alu_a, alu_b, ex_store_data;
  logic [3:0]        alu_control;
  logic [REG_AW-1:0] ex_rd_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_alu_control(in_alu_control), .in_src_a_pc(in_src_a_pc), .in_src_b_imm(in_src_b_imm),
    .in_reg_write(in_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
  );

  // Behavioural model: the instruction currently held in EX.
  typedef struct {
    bit        valid;
    bit [31:0] pc, rs1_data, rs2_data, imm;
    bit [4:0]  rs1, rs2, rd;
    bit [3:0]  ctrl;
    bit        a_pc, b_imm, wr;
  } instr_t;
  instr_t m;

  function automatic bit [31:0] operand(input bit [4:0] src, input bit [31:0] held);
    if (src == 0) return held;
    if (exmem_reg_write && exmem_rd == src) return exmem_result;
    if (memwb_reg_write && memwb_rd == src) return memwb_result;
    return held;
  endfunction

  task automatic drive_idle();
    rst = 0; stall = 0; flush = 0; in_valid = 0;
    in_pc = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0; in_alu_control = 0;
    in_src_a_pc = 0; in_src_b_imm = 0; in_reg_write = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic load_instr(input bit [4:0] rs1, input bit [31:0] d1, input bit [4:0] rs2,
                            input bit [31:0] d2, input bit [4:0] rd, input bit [3:0] ctrl);
    in_valid = 1; in_reg_write = 1; in_pc = 32'h100;
    in_rs1_addr = rs1; in_rs1_data = d1; in_rs2_addr = rs2; in_rs2_data = d2;
    in_rd_addr = rd; in_alu_control = ctrl; in_src_a_pc = 0; in_src_b_imm = 0; in_imm = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; stall = 1; flush = 1; in_valid = 1; in_reg_write = 1;
    in_pc = '1; in_rs1_data = '1; in_rs2_data = '1; in_imm = '1;
    in_rs1_addr = '1; in_rs2_addr = '1; in_rd_addr = '1; in_alu_control = '1;
    in_src_a_pc = 1; in_src_b_imm = 1;
    exmem_reg_write = 1; exmem_rd = '1; exmem_result = '1;
    memwb_reg_write = 1; memwb_rd = '1; memwb_result = '1;
    @(posedge clk); #1;
    n_tests++;
    if ({ex_valid, ex_reg_write, alu_control, ex_rd_addr} !== 11'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got v=%0b rw=%0b ctrl=%h rd=%0d, want all 0",
                         ex_valid, ex_reg_write, alu_control, ex_rd_addr);
    end
    n_tests++;
    if ({alu_a, alu_b, ex_store_data} !== 96'd0) begin
      n_fail++; $display("FAIL reset_data: got a=%h b=%h st=%h, want 0", alu_a, alu_b, ex_store_data);
    end
    $display("[TB] reset done");
    @(negedge clk); drive_idle();
  endtask

  task automatic test_load();
    @(negedge clk); drive_idle();
    load_instr(5'd1, 32'd5, 5'd2, 32'd10, 5'd6, 4'b0000);
    @(posedge clk); #1;
    n_tests++;
    if (alu_a !== 32'd5 || alu_b !== 32'd10) begin
      n_fail++; $display("FAIL load_ops: got a=%0d b=%0d, want 5 10", alu_a, alu_b);
    end
    n_tests++;
    if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_rd_addr !== 5'd6) begin
      n_fail++; $display("FAIL load_ctrl: got v=%0b rw=%0b rd=%0d, want 1 1 6", ex_valid, ex_reg_write, ex_rd_addr);
    end
    @(negedge clk); in_src_b_imm = 1; in_imm = 32'd7;
    @(posedge clk); #1;
    n_tests++;
    if (alu_b !== 32'd7 || ex_store_data !== 32'd10) begin
      n_fail++; $display("FAIL load_imm: got b=%0d st=%0d, want 7 10", alu_b, ex_store_data);
    end
    $display("[TB] load done");
  endtask

  task automatic test_forward();
    @(negedge clk); drive_idle();
    load_instr(5'd3, 32'd1, 5'd3, 32'd2, 5'd7, 4'b0001);
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'd12;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'd99;
    @(posedge clk); #1;
    n_tests++;
    if (alu_a !== 32'd12 || alu_b !== 32'd12 || ex_store_data !== 32'd12) begin
      n_fail++; $display("FAIL fwd_exmem: got a=%0d b=%0d st=%0d, want 12", alu_a, alu_b, ex_store_data);
    end
    @(negedge clk); exmem_reg_write = 0; #1;
    n_tests++;
    if (alu_a !== 32'd99 || alu_b !== 32'd99 || ex_store_data !== 32'd99) begin
      n_fail++; $display("FAIL fwd_memwb: got a=%0d b=%0d st=%0d, want 99", alu_a, alu_b, ex_store_data);
    end
    $display("[TB] forward done");
  endtask

  task automatic test_x0_guard();
    @(negedge clk); drive_idle();
    load_instr(5'd0, 32'd0, 5'd0, 32'h33, 5'd1, 4'b0000);
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'd55;
    memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'd66;
    @(posedge clk); #1;
    n_tests++;
    if (alu_a !== 32'd0 || alu_b !== 32'h33) begin
      n_fail++; $display("FAIL x0_guard: got a=%0d b=%h, want 0 33", alu_a, alu_b);
    end
    $display("[TB] x0 guard done");
  endtask

  task automatic test_stall_refresh();
    @(negedge clk); drive_idle();
    load_instr(5'd4, 32'd1, 5'd5, 32'd2, 5'd9, 4'b0101);
    @(posedge clk);
    @(negedge clk);
    stall = 1; in_rs1_data = 32'hDEAD; in_rs2_data = 32'hBEEF; in_rd_addr = 5'd30;
    in_alu_control = 4'b1111; in_valid = 0;
    memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'd77;
    @(posedge clk);
    @(negedge clk); memwb_reg_write = 0; memwb_result = 0;
    @(posedge clk);
    @(negedge clk); stall = 0; #1;
    n_tests++;
    if (alu_a !== 32'd77) begin
      n_fail++; $display("FAIL stall_refresh: got a=%0d, want 77", alu_a);
    end
    n_tests++;
    if (alu_b !== 32'd2 || alu_control !== 4'b0101 || ex_rd_addr !== 5'd9 || ex_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_hold: got b=%0d ctrl=%h rd=%0d v=%0b, want 2 5 9 1",
                         alu_b, alu_control, ex_rd_addr, ex_valid);
    end
    $display("[TB] stall refresh done");
  endtask

  task automatic test_flush();
    @(negedge clk); drive_idle();
    load_instr(5'd1, 32'd3, 5'd2, 32'd4, 5'd8, 4'b0011);
    @(posedge clk);
    @(negedge clk); flush = 1; stall = 1;
    @(posedge clk); #1;
    n_tests++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_control !== 4'b0000 || alu_a !== 0 || alu_b !== 0) begin
      n_fail++; $display("FAIL flush_bubble: got v=%0b rw=%0b ctrl=%h a=%0d b=%0d, want 0",
                         ex_valid, ex_reg_write, alu_control, alu_a, alu_b);
    end
    @(negedge clk); flush = 0; stall = 0;
    @(posedge clk);
    @(negedge clk); stall = 1; rst = 1;
    @(posedge clk); #1;
    n_tests++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_control !== 4'b0000 || ex_rd_addr !== 0) begin
      n_fail++; $display("FAIL rst_in_stall: got v=%0b rw=%0b ctrl=%h rd=%0d, want 0",
                         ex_valid, ex_reg_write, alu_control, ex_rd_addr);
    end
    $display("[TB] flush done");
    @(negedge clk); drive_idle();
  endtask

  task automatic test_random();
    bit [31:0] ea, eb, es;
    bit        ev, erw;
    @(negedge clk); drive_idle(); rst = 1;
    @(posedge clk);
    m = '{default: 0};
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 99) < 3);
      flush = ($urandom_range(0, 99) < 10);
      stall = ($urandom_range(0, 99) < 25);
      in_valid = $urandom_range(0, 1); in_reg_write = $urandom_range(0, 1);
      in_pc = $urandom; in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
      in_rs1_addr = 5'($urandom_range(0, 7)); in_rs2_addr = 5'($urandom_range(0, 7));
      in_rd_addr = 5'($urandom); in_alu_control = 4'($urandom);
      in_src_a_pc = $urandom_range(0, 1); in_src_b_imm = $urandom_range(0, 1);
      exmem_reg_write = $urandom_range(0, 1); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
      memwb_reg_write = $urandom_range(0, 1); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
      if (rst || flush) m = '{default: 0};
      else if (stall) begin
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == m.rs1) m.rs1_data = memwb_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == m.rs2) m.rs2_data = memwb_result;
      end else begin
        m.valid = in_valid; m.pc = in_pc; m.rs1_data = in_rs1_data; m.rs2_data = in_rs2_data;
        m.imm = in_imm; m.rs1 = in_rs1_addr; m.rs2 = in_rs2_addr; m.rd = in_rd_addr;
        m.ctrl = in_alu_control; m.a_pc = in_src_a_pc; m.b_imm = in_src_b_imm;
        m.wr = in_valid && in_reg_write;
      end
      @(posedge clk); #1;
      es  = operand(m.rs2, m.rs2_data);
      ea  = m.a_pc ? m.pc : operand(m.rs1, m.rs1_data);
      eb  = m.b_imm ? m.imm : es;
      ev  = m.valid;
      erw = m.valid && m.wr;
      n_tests++;
      if ({ex_valid, alu_a, alu_b, alu_control, ex_store_data, ex_rd_addr, ex_reg_write} !==
          {ev, ea, eb, m.ctrl, es, m.rd, erw}) begin
        n_fail++;
        $display("FAIL rand_%0d: got v=%0b a=%h b=%h c=%h st=%h rd=%0d rw=%0b, want v=%0b a=%h b=%h c=%h st=%h rd=%0d rw=%0b",
                 cyc, ex_valid, alu_a, alu_b, alu_control, ex_store_data, ex_rd_addr, ex_reg_write,
                 ev, ea, eb, m.ctrl, es, m.rd, erw);
      end else
        $display("[TB] rand %0d ok a=%h b=%h", cyc, alu_a, alu_b);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_load();
    test_forward();
    test_x0_guard();
    test_stall_refresh();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
